// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, one bit per cycle.
// Signed operations work on magnitudes, and the signs are applied in the FIX state.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      cnt_reg;
    logic [2*WIDTH-1:0] acc_reg;      // mult: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opb_reg;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   raw_a_reg;    // original dividend, returned as HI on divide by zero
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               is_div_reg, neg_q_reg, neg_r_reg, dz_pend_reg;
    logic               done_reg, div_zero_reg;

    // Operand decode for a start request made in IDLE
    logic               accept_iter;
    logic               op_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign accept_iter = (state_reg == IDLE) && start && !flush && !op[2];
    assign op_signed   = !op[0];
    assign a_neg       = op_signed && src_a[WIDTH-1];
    assign b_neg       = op_signed && src_b[WIDTH-1];
    assign a_mag       = a_neg ? -src_a : src_a;
    assign b_mag       = b_neg ? -src_b : src_b;

    // One radix-2 step for each operation
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_neg;

    // Combinational datapath: shift-add step, trial-subtract step, and product negation
    always_comb begin
        mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opb_reg} : '0);
        mul_next = {mul_sum, acc_reg[WIDTH-1:1]};
        div_diff = acc_reg[2*WIDTH-1:WIDTH-1] - {1'b0, opb_reg};
        if (div_diff[WIDTH])
            div_next = {acc_reg[2*WIDTH-2:0], 1'b0};
        else
            div_next = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
        prod_neg = -acc_reg;
    end

    // State register
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic: flush always returns the FSM to IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept_iter) state_next = CALC;
            CALC: begin
                if (flush)
                    state_next = IDLE;
                else if (cnt_reg == LAST_ITER)
                    state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            cnt_reg      <= '0;
            acc_reg      <= '0;
            opb_reg      <= '0;
            raw_a_reg    <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            is_div_reg   <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            dz_pend_reg  <= 1'b0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept_iter) begin
                        cnt_reg     <= '0;
                        is_div_reg  <= op[1];
                        neg_q_reg   <= a_neg ^ b_neg;
                        neg_r_reg   <= a_neg;
                        dz_pend_reg <= op[1] && (src_b == '0);
                        raw_a_reg   <= src_a;
                        if (op[1]) begin
                            acc_reg <= {{WIDTH{1'b0}}, a_mag};
                            opb_reg <= b_mag;
                        end else begin
                            acc_reg <= {{WIDTH{1'b0}}, b_mag};
                            opb_reg <= a_mag;
                        end
                    end else if (start && !flush && op == 3'b100) begin
                        hi_reg <= src_a;
                    end else if (start && !flush && op == 3'b101) begin
                        lo_reg <= src_a;
                    end
                end
                CALC: begin
                    if (!flush) begin
                        acc_reg <= is_div_reg ? div_next : mul_next;
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        done_reg <= 1'b1;
                        if (!is_div_reg) begin
                            {hi_reg, lo_reg} <= neg_q_reg ? prod_neg : acc_reg;
                        end else begin
                            div_zero_reg <= dz_pend_reg;
                            if (dz_pend_reg) begin
                                hi_reg <= raw_a_reg;
                                lo_reg <= '1;
                            end else begin
                                lo_reg <= neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
                                hi_reg <= neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH]
                                                    : acc_reg[2*WIDTH-1:WIDTH];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
    assign div_zero = div_zero_reg;
    assign hi       = hi_reg;
    assign lo       = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit. Expected HI/LO/div_zero values are queued when an
// operation is issued, and a monitor compares them whenever done pulses.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         sysclk = 1'b0;
    logic         reset  = 1'b1;
    logic         start  = 1'b0;
    logic         flush  = 1'b0;
    logic [2:0]   op     = 3'b000;
    logic [W-1:0] src_a  = '0;
    logic [W-1:0] src_b  = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge sysclk) begin
        if (!reset && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 hi=%h lo=%h", hi, lo);
            end else begin
                mon_e = sb_q.pop_front();
                $display("txn done hi=%h lo=%h div_zero=%0b (expected %h %h %0b)",
                         hi, lo, div_zero, mon_e.hi, mon_e.lo, mon_e.dz);
                check("sb_hi", 64'(hi), 64'(mon_e.hi));
                check("sb_lo", 64'(lo), 64'(mon_e.lo));
                check("sb_div_zero", 64'(div_zero), 64'(mon_e.dz));
            end
        end
    end

    // Issue one iterative op, queue its expected result and measure the busy duration
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz,
                         input bit b2b);
        int n;
        if (!b2b) @(negedge sysclk);
        sb_q.push_back('{hi: eh, lo: el, dz: edz});
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge sysclk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge sysclk);
        end
        check("busy_cycles", 64'(n), 64'(W + 1));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        int done_seen;
        // Reset state
        #2;
        check("rst_hi", 64'(hi), 64'h0);
        check("rst_lo", 64'(lo), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_div_zero", 64'(div_zero), 64'h0);
        @(negedge sysclk);
        reset = 1'b0;

        // MTLO while idle
        @(negedge sysclk);
        start = 1'b1; op = 3'b101; src_a = 32'h0000_1234;
        @(negedge sysclk);
        start = 1'b0;
        $display("txn MTLO lo=%h busy=%0b", lo, busy);
        check("mtlo_lo", 64'(lo), 64'h0000_1234);
        check("mtlo_hi", 64'(hi), 64'h0);
        check("mtlo_busy", 64'(busy), 64'h0);

        // MULT 2*3 with an MTHI attempted while busy
        sb_q.push_back('{hi: 32'h0, lo: 32'h6, dz: 1'b0});
        start = 1'b1; op = 3'b000; src_a = 32'd2; src_b = 32'd3;
        @(negedge sysclk);
        start = 1'b1; op = 3'b100; src_a = 32'hFFFF_FFFF;
        @(negedge sysclk);
        start = 1'b0;
        @(negedge sysclk);
        $display("txn MTHI while busy hi=%h busy=%0b", hi, busy);
        check("mthi_busy_hi", 64'(hi), 64'h0);
        check("mthi_busy_busy", 64'(busy), 64'h1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge sysclk);
        end
        check("mult_small_done_seen", 64'(n > 0 && n < 100), 64'h1);

        do_op(3'b000, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0);
        do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
        // Back-to-back start in the done cycle
        do_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);
        do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
        do_op(3'b011, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1'b0);
        do_op(3'b001, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 32'h0000_002A, 1'b1, 1'b0);
        do_op(3'b011, 32'h0000_000A, 32'h0000_0003, 32'h0000_0001, 32'h0000_0003, 1'b0, 1'b0);

        // Flush beats a same-cycle start in IDLE
        @(negedge sysclk);
        start = 1'b1; flush = 1'b1; op = 3'b100; src_a = 32'h5555_5555;
        @(negedge sysclk);
        op = 3'b000;
        @(negedge sysclk);
        start = 1'b0; flush = 1'b0;
        $display("txn flush+start idle hi=%h busy=%0b", hi, busy);
        check("idle_flush_hi", 64'(hi), 64'h1);
        check("idle_flush_busy", 64'(busy), 64'h0);

        // Flush in busy cycle 10
        start = 1'b1; op = 3'b001; src_a = 32'd5; src_b = 32'd5;
        @(negedge sysclk);
        start = 1'b0;
        for (int c = 2; c <= 10; c++) @(negedge sysclk);
        check("flush_pre_busy", 64'(busy), 64'h1);
        flush = 1'b1;
        @(negedge sysclk);
        flush = 1'b0;
        $display("txn flush mid-CALC busy=%0b hi=%h lo=%h", busy, hi, lo);
        check("flush_busy", 64'(busy), 64'h0);
        check("flush_hi", 64'(hi), 64'h1);
        check("flush_lo", 64'(lo), 64'h3);
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) done_seen++;
            @(negedge sysclk);
        end
        check("flush_no_done", 64'(done_seen), 64'h0);

        // Set div_zero again, then reset mid-CALC
        do_op(3'b011, 32'h0000_0009, 32'h0000_0000, 32'h0000_0009, 32'hFFFF_FFFF, 1'b1, 1'b0);
        @(negedge sysclk);
        start = 1'b1; op = 3'b010; src_a = 32'd100; src_b = 32'd7;
        @(negedge sysclk);
        start = 1'b0;
        for (int c = 0; c < 5; c++) @(negedge sysclk);
        #1 reset = 1'b1;
        #1;
        $display("txn async reset busy=%0b hi=%h lo=%h div_zero=%0b", busy, hi, lo, div_zero);
        check("arst_busy", 64'(busy), 64'h0);
        check("arst_hi", 64'(hi), 64'h0);
        check("arst_lo", 64'(lo), 64'h0);
        check("arst_div_zero", 64'(div_zero), 64'h0);
        check("arst_done", 64'(done), 64'h0);
        @(negedge sysclk);
        reset = 1'b0;
        repeat (3) @(negedge sysclk);

        check("sb_empty", 64'(sb_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers, for the EX stage of the next-generation pipelined CPU.
- Accepts one operation per start pulse and computes over WIDTH cycles.
- Drives busy, which the hazard logic uses to stall dependent MFHI/MFLO and new MDU ops.
- Supports a flush input so exceptions and branch squash can abort an in-flight operation.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
- sysclk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  request operation; sampled only when busy=0.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- src_a  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data).
- src_b  input  WIDTH  rt operand (multiplier / divisor).
- flush  input  1  abort in-flight operation / cancel same-cycle start.
- busy  output  1  high while an iterative op is in progress.
- done  output  1  one-cycle pulse when HI/LO have just been updated by MULT/DIV.
- div_zero  output  1  sticky flag: last completed DIV/DIVU had divisor 0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - state=IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0.
  - Iteration counter and work registers are cleared.
- States: IDLE, CALC, FIX. busy = (state != IDLE), decoded from registered state.
- IDLE, start=1, flush=0:
  - Ops 000-011: latch absolute values of operands (signed ops only) and result-sign bits; counter=0; go to CALC.
  - MTHI: hi<=src_a at that edge; state stays IDLE; no busy, no done. MTLO likewise for lo.
  - No-op codes: ignored.
- CALC: one radix-2 iteration per cycle for exactly WIDTH cycles; counter increments and goes to FIX after iteration WIDTH-1.
  - Multiply: shift-add into a 2*WIDTH product register.
  - Divide: restoring shift-subtract on magnitudes.
- FIX: apply signs, write hi/lo, go to IDLE, set done=1 for the next cycle only.
  - MULT: {hi,lo} = two's-complement of product if sign_a^sign_b.
  - DIV: lo = quotient, negated if sign_a^sign_b; hi = remainder, negated if sign_a (remainder takes the dividend's sign).
- Latency:
  - Start accepted at edge T gives busy=1 in cycles T+1 .. T+WIDTH+1.
  - hi/lo update at edge T+WIDTH+1; done=1 and busy=0 in the following cycle.
  - A new start may be accepted in that same done cycle.
- Division by zero (divisor==0, checked at start):
  - Result: hi = src_a unchanged, lo = all ones.
  - div_zero is set at the FIX edge; it clears at the FIX edge of the next DIV/DIVU with a nonzero divisor.
  - The full WIDTH-cycle timing is still honoured.
- Signed overflow, DIV most-negative / -1: lo = 100..0, hi = 0. No flag.
- start while busy: ignored. The pipeline must hold the instruction via the stall derived from busy.
- MTHI/MTLO while busy: ignored.
- flush:
  - In CALC or FIX: state goes to IDLE at the next edge; hi/lo/div_zero unchanged; no done pulse; busy=0 the next cycle.
  - In IDLE with start=1: flush wins; nothing is written.
- hi/lo are held constant during CALC, so MFHI/MFLO reads return the pre-operation values (hazard logic stalls them anyway).
- Width rules:
  - Internal product/remainder registers are 2*WIDTH wide.
  - Counter width is clog2(WIDTH)+1.
  - No truncation of the product before the HI/LO split.

Test Plan (WIDTH=32):
- MULT src_a=FFFFFFFD (-3), src_b=00000005 -> busy for 33 cycles, then done pulse; hi=FFFFFFFF, lo=FFFFFFF1.
- MULTU FFFFFFFF x FFFFFFFF -> hi=FFFFFFFE, lo=00000001; a back-to-back start accepted in the done cycle is taken.
- DIV FFFFFFF9 (-7) / 00000002 -> lo=FFFFFFFD, hi=FFFFFFFF, div_zero=0. DIV 80000000 / FFFFFFFF -> lo=80000000, hi=0.
- DIVU 00000064 / 0 -> after 33 cycles hi=00000064, lo=FFFFFFFF, div_zero=1; then DIVU 10/3 -> lo=3, hi=1, div_zero=0.
- With hi=lo=0: MTLO 1234 when idle -> lo=00001234 at the next edge, busy stays 0; MTHI issued while busy -> hi unchanged.
- Flush and reset:
  - Start MULT, assert flush in cycle 10 -> busy=0 in cycle 11, hi/lo keep prior values, no done.
  - Reset asserted mid-CALC -> all outputs 0 immediately, without a clock edge.
